// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap sequencer between idex and the CSR file.
// Arbitrates exceptions, maskable interrupts, mret and wfi. It performs the
// mstatus/mepc/mcause(/mtval) update sequence through a single CSR port,
// then redirects the PC to mtvec (direct or vectored) or back to mepc.
// Optional feature macro: TRAP_MTVAL_EN (adds the WTVL state and tval_q).
module trap_ctrl #(
    parameter int IRQ_N          = 3,
    parameter bit MTVEC_VEC_EN_P = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      csr_rdata_i,
    output logic [31:0]      csr_wdata_o,
    output logic             csr_we_o,
    output logic [11:0]      csr_addr_o,
    input  logic             ecall_i,
    input  logic             ebreak_i,
    input  logic             inst_err_i,
    input  logic [IRQ_N-1:0] irq_i,
    input  logic             mstatus_MIE3,
    input  logic             wfi_i,
    input  logic             mret_i,
    input  logic [31:0]      tval_i,
    input  logic [31:0]      pc_i,
    input  logic [31:0]      pc_n_i,
    output logic [31:0]      pc_n_o,
    output logic             trap_jump_o,
    output logic             trap_in_o
);

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MTVAL   = 12'h343;

    typedef enum logic [3:0] {
        IDLE,
        SWFI,
        CMIE,
        WEPC,
        WCAU,
`ifdef TRAP_MTVAL_EN
        WTVL,
`endif
        JUMP,
        MRST,
        MRJP
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
`ifdef TRAP_MTVAL_EN
    logic [31:0] tval_q, tval_d;
`else
    logic        unused_tval;
    assign unused_tval = ^tval_i;
`endif

    logic        exc_hit;
    logic [4:0]  exc_code;
    logic [31:0] exc_tval;
    logic        irq_hit;
    logic [4:0]  irq_code;
    logic        take_exc;
    logic        take_irq;
    logic [31:0] mtvec_base;

    // Exception priority: inst_err > ebreak > ecall (later assignment wins)
    always_comb begin
        exc_hit  = ecall_i | ebreak_i | inst_err_i;
        exc_code = 5'd0;
        exc_tval = 32'd0;
        if (ecall_i)    exc_code = 5'd11;
        if (ebreak_i) begin
            exc_code = 5'd3;
            exc_tval = pc_i;
        end
        if (inst_err_i) begin
            exc_code = 5'd2;
            exc_tval = tval_i;
        end
    end

    // Interrupt priority: highest local line first, then MEI > MSI > MTI
    always_comb begin
        irq_hit  = |irq_i;
        irq_code = 5'd0;
        if (irq_i[1]) irq_code = 5'd7;
        if (irq_i[0]) irq_code = 5'd3;
        if (irq_i[2]) irq_code = 5'd11;
        for (int k = 3; k < IRQ_N; k++) begin
            if (irq_i[k]) irq_code = 5'(13 + k);
        end
    end

    // Next-state and trap-context capture
    always_comb begin
        state_d  = state_q;
        cause_d  = cause_q;
        epc_d    = epc_q;
`ifdef TRAP_MTVAL_EN
        tval_d   = tval_q;
`endif
        take_exc = 1'b0;
        take_irq = 1'b0;
        case (state_q)
            IDLE: begin
                if (exc_hit)                      take_exc = 1'b1;
                else if (irq_hit && mstatus_MIE3) take_irq = 1'b1;
                else if (mret_i)                  state_d  = MRST;
                else if (wfi_i)                   state_d  = SWFI;
            end
            SWFI: begin
                if (exc_hit)             take_exc = 1'b1;
                else if (irq_hit) begin
                    if (mstatus_MIE3)    take_irq = 1'b1;
                    else                 state_d  = IDLE;
                end
            end
            CMIE: state_d = WEPC;
            WEPC: state_d = WCAU;
`ifdef TRAP_MTVAL_EN
            WCAU: state_d = WTVL;
            WTVL: state_d = JUMP;
`else
            WCAU: state_d = JUMP;
`endif
            JUMP: state_d = IDLE;
            MRST: state_d = MRJP;
            MRJP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (take_exc) begin
            cause_d = {1'b0, 26'd0, exc_code};
            epc_d   = pc_i;
`ifdef TRAP_MTVAL_EN
            tval_d  = exc_tval;
`endif
            state_d = CMIE;
        end
        if (take_irq) begin
            cause_d = {1'b1, 26'd0, irq_code};
            epc_d   = pc_n_i;
`ifdef TRAP_MTVAL_EN
            tval_d  = 32'd0;
`endif
            state_d = CMIE;
        end
    end

    // State and latched trap context
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cause_q <= 32'd0;
            epc_q   <= 32'd0;
`ifdef TRAP_MTVAL_EN
            tval_q  <= 32'd0;
`endif
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            epc_q   <= epc_d;
`ifdef TRAP_MTVAL_EN
            tval_q  <= tval_d;
`endif
        end
    end

    assign mtvec_base = {csr_rdata_i[31:2], 2'b00};

    // CSR port and PC redirect, decoded from the current state
    always_comb begin
        csr_addr_o  = 12'h000;
        csr_we_o    = 1'b0;
        csr_wdata_o = 32'd0;
        pc_n_o      = pc_n_i;
        trap_jump_o = 1'b0;
        trap_in_o   = (state_q != IDLE) && (state_q != SWFI);
        case (state_q)
            CMIE: begin
                csr_addr_o     = ADDR_MSTATUS;
                csr_wdata_o    = csr_rdata_i;
                csr_wdata_o[7] = csr_rdata_i[3];
                csr_wdata_o[3] = 1'b0;
                csr_we_o       = 1'b1;
            end
            WEPC: begin
                csr_addr_o  = ADDR_MEPC;
                csr_wdata_o = epc_q;
                csr_we_o    = 1'b1;
            end
            WCAU: begin
                csr_addr_o  = ADDR_MCAUSE;
                csr_wdata_o = cause_q;
                csr_we_o    = 1'b1;
            end
`ifdef TRAP_MTVAL_EN
            WTVL: begin
                csr_addr_o  = ADDR_MTVAL;
                csr_wdata_o = tval_q;
                csr_we_o    = 1'b1;
            end
`endif
            JUMP: begin
                csr_addr_o  = ADDR_MTVEC;
                trap_jump_o = 1'b1;
                if (MTVEC_VEC_EN_P && cause_q[31] && (csr_rdata_i[1:0] == 2'b01))
                    pc_n_o = mtvec_base + (32'(cause_q[4:0]) << 2);
                else
                    pc_n_o = mtvec_base;
            end
            MRST: begin
                csr_addr_o     = ADDR_MSTATUS;
                csr_wdata_o    = csr_rdata_i;
                csr_wdata_o[3] = csr_rdata_i[7];
                csr_wdata_o[7] = 1'b1;
                csr_we_o       = 1'b1;
            end
            MRJP: begin
                csr_addr_o  = ADDR_MEPC;
                pc_n_o      = {csr_rdata_i[31:2], 2'b00};
                trap_jump_o = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
